restoring_divider: RTL and testbench

Sequential radix-2 restoring divider. It is the inverse companion of the team's 16x16 multiplier: it divides a 32-bit dividend (a product-width value) by a 16-bit divisor and returns the quotient and remainder. Operation uses a start/done handshake and retires one quotient bit per clock. It sits beside the multiplier in the datapath's arithmetic unit.

---
 rtl/arith_pkg.sv | 18 +
 rtl/restoring_divider_div_step.sv | 26 ++
 rtl/restoring_divider.sv | 119 +++++++++++
 tb/tb_restoring_divider.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/arith_pkg.sv
// Shared arithmetic-unit package: divider FSM encoding and the
// operand widths used by both the multiplier and the divider.
package arith_pkg;

  localparam int MUL_AW = 16;
  localparam int MUL_PW = 2 * MUL_AW;

  localparam int DIV_DW = MUL_PW;
  localparam int DIV_VW = MUL_AW;
  localparam int DIV_CW = 6;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } div_state_t;

endpackage

// File: rtl/restoring_divider_div_step.sv
// One radix-2 restoring iteration; combinational so it can be
// unrolled. q_o[0] carries the newly retired quotient bit.
module div_step #(
  parameter int DW = 32,
  parameter int VW = 16
) (
  input  logic [VW-1:0] r_i,
  input  logic [DW-1:0] q_i,
  input  logic [VW-1:0] d_i,
  output logic [VW-1:0] r_o,
  output logic [DW-1:0] q_o
);

  logic [VW:0] r_sh;
  logic [VW:0] t;
  logic        qbit;

  assign r_sh = {r_i, q_i[DW-1]};
  assign t    = r_sh - {1'b0, d_i};
  assign qbit = ~t[VW];

  // R stays below the divisor, so both candidates fit in VW bits
  assign r_o = qbit ? t[VW-1:0] : r_sh[VW-1:0];
  assign q_o = {q_i[DW-2:0], qbit};

endmodule

// File: rtl/restoring_divider.sv
// Sequential radix-2 restoring divider, one quotient bit per clock.
// Define EARLY_TERM_EN to short-cut divisions with dividend < divisor.
import arith_pkg::*;

module restoring_divider #(
  parameter int DW = DIV_DW,
  parameter int VW = DIV_VW,
  parameter int CW = DIV_CW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          busy,
  output logic          done,
  output logic          div_by_zero
);

  div_state_t    state_q;
  logic [CW-1:0] cnt_q;
  logic [VW-1:0] r_q;
  logic [DW-1:0] q_q;
  logic [VW-1:0] dvs_q;
  logic          dbz_q;

  logic [DW-1:0] quot_q;
  logic [VW-1:0] rem_q;
  logic          busy_q;
  logic          done_q;
  logic          dbz_out_q;

  logic [VW-1:0] r_d;
  logic [DW-1:0] q_d;

  div_step #(
    .DW (DW),
    .VW (VW)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (dvs_q),
    .r_o (r_d),
    .q_o (q_d)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      r_q       <= '0;
      q_q       <= '0;
      dvs_q     <= '0;
      dbz_q     <= 1'b0;
      quot_q    <= '0;
      rem_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dbz_out_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (divisor == '0) begin
              q_q     <= '1;
              r_q     <= '0;
              dbz_q   <= 1'b1;
              state_q <= FINISH;
`ifdef EARLY_TERM_EN
            end else if ({{(DW-VW){1'b0}}, divisor} > dividend) begin
              q_q       <= '0;
              r_q       <= dividend[VW-1:0];
              dbz_q     <= 1'b0;
              dbz_out_q <= 1'b0;
              state_q   <= FINISH;
`endif
            end else begin
              dvs_q     <= divisor;
              q_q       <= dividend;
              r_q       <= '0;
              cnt_q     <= '0;
              dbz_q     <= 1'b0;
              dbz_out_q <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= RUN;
            end
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(DW - 1)) begin
            busy_q  <= 1'b0;
            state_q <= FINISH;
          end
        end
        FINISH: begin
          quot_q    <= q_q;
          rem_q     <= r_q;
          dbz_out_q <= dbz_q;
          done_q    <= 1'b1;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_restoring_divider.sv
// Directed bench for restoring_divider: arithmetic reference model
// compared every cycle, plus hand-computed result/latency checks.
module tb_restoring_divider;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic [31:0] quotient;
  logic [15:0] remainder;
  logic        busy;
  logic        done;
  logic        div_by_zero;

  int vectors;
  int miscompares;
  int done_cnt;
  int cyc;

`ifdef EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  restoring_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: results land a fixed number of edges after acceptance
  logic [31:0] m_q, p_q;
  logic [15:0] m_r, p_r;
  logic        m_dbz, p_dbz, m_done, m_long;
  int          m_left;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= 0; m_r <= 0; m_dbz <= 0; m_done <= 0;
      m_left <= 0; m_long <= 0;
      p_q <= 0; p_r <= 0; p_dbz <= 0;
    end else begin
      m_done <= 0;
      if (m_left == 0) begin
        if (start) begin
          if (divisor == 0) begin
            p_q <= 32'hFFFF_FFFF;
            p_r <= 0;
            p_dbz <= 1;
            m_long <= 0;
            m_left <= 1;
          end else begin
            p_q <= dividend / {16'd0, divisor};
            p_r <= 16'(dividend % {16'd0, divisor});
            p_dbz <= 0;
            m_dbz <= 0;
            if (EARLY && dividend < {16'd0, divisor}) begin
              m_long <= 0;
              m_left <= 1;
            end else begin
              m_long <= 1;
              m_left <= 33;
            end
          end
        end
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_q <= p_q; m_r <= p_r; m_dbz <= p_dbz; m_done <= 1;
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (done) done_cnt++;
    check("quotient", quotient, m_q);
    check("remainder", {16'd0, remainder}, {16'd0, m_r});
    check("busy", {31'd0, busy}, {31'd0, m_long && m_left >= 2});
    check("done", {31'd0, done}, {31'd0, m_done});
    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, m_dbz});
  end

  task automatic run_op(input string nm, input logic [31:0] a,
                        input logic [15:0] b, input logic [31:0] eq,
                        input logic [15:0] er, input logic ez,
                        input int elat);
    int k;
    k = 0;
    @(negedge clk);
    start = 1; dividend = a; divisor = b;
    @(negedge clk);
    start = 0; dividend = ~a; divisor = b + 16'd3;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin k = i; break; end
    end
    check({nm, " latency"}, k, elat);
    check({nm, " q"}, quotient, eq);
    check({nm, " r"}, {16'd0, remainder}, {16'd0, er});
    check({nm, " dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    @(negedge clk);
    check({nm, " done width"}, {31'd0, done}, 32'd0);
  endtask

  int d0, t1, t2;

  initial begin
    vectors = 0; miscompares = 0; done_cnt = 0; cyc = 0;
    reset = 1; start = 0; dividend = 0; divisor = 0;
    @(negedge clk);
    check("rst q", quotient, 0);
    check("rst flags", {29'd0, busy, done, div_by_zero}, 0);
    @(negedge clk);
    reset = 0;

    run_op("100/7", 100, 7, 14, 2, 0, 33);
    run_op("max/ffff", 32'hFFFF_FFFF, 16'hFFFF, 32'h0001_0001, 0, 0, 33);
    run_op("sq/ffff", 32'hFFFE_0001, 16'hFFFF, 32'h0000_FFFF, 0, 0, 33);
    run_op("1234/0", 1234, 0, 32'hFFFF_FFFF, 0, 1, 1);
    run_op("10/3", 10, 3, 3, 1, 0, 33);
    run_op("5/9", 5, 9, 0, 5, 0, EARLY ? 1 : 33);

    // second request during RUN must be dropped
    d0 = done_cnt;
    @(negedge clk);
    start = 1; dividend = 500; divisor = 9;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    start = 1; dividend = 8; divisor = 2;
    @(negedge clk);
    start = 0;
    repeat (50) @(negedge clk);
    check("ignore dones", done_cnt - d0, 1);
    check("ignore q", quotient, 55);
    check("ignore r", {16'd0, remainder}, 5);

    // start held high: operations 34 cycles apart
    t1 = 0; t2 = 0;
    start = 1; dividend = 20; divisor = 6;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) begin
        if (t1 == 0) t1 = cyc;
        else begin t2 = cyc; break; end
      end
    end
    start = 0;
    check("b2b spacing", t2 - t1, 34);
    check("b2b q", quotient, 3);
    check("b2b r", {16'd0, remainder}, 2);

    // reset mid-operation
    @(negedge clk);
    start = 1; dividend = 1000; divisor = 3;
    @(negedge clk);
    start = 0;
    repeat (9) @(negedge clk);
    d0 = done_cnt;
    @(posedge clk);
    #2 reset = 1;
    #1;
    check("abort q", quotient, 0);
    check("abort r", {16'd0, remainder}, 0);
    check("abort flags", {29'd0, busy, done, div_by_zero}, 0);
    @(negedge clk);
    reset = 0;
    repeat (40) @(negedge clk);
    check("abort no done", done_cnt - d0, 0);
    run_op("7/7", 7, 7, 1, 0, 0, 33);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
